mem_arbiter: RTL and testbench

Round-robin arbiter that shares one simple memory port between `NUM_REQ` processors. Each requester side matches the processor memory interface (`mem_ce/we/addr/width/data/ready`), and the single downstream side drives one `mem_axi` instance. This lets several `proc` cores share one AXI master instead of each core owning its own. The arbiter serialises whole transactions, latches the winner's command, and routes the completion back to the winner only.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_rr_pick.sv | 31 +++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the round-robin memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_BUS = 32;
  localparam int unsigned DATA_BUS = 32;
  localparam int unsigned WIDTH_W  = 4;
  localparam int unsigned WD_W     = 10;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } arb_state_t;

  // Latched downstream command of the current winner.
  typedef struct packed {
    logic                we;
    logic [ADDR_BUS-1:0] addr;
    logic [WIDTH_W-1:0]  width;
    logic [DATA_BUS-1:0] data;
  } mem_cmd_t;

  function automatic int unsigned ARB_PTR_W(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping at N-1.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = ARB_PTR_W(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] winner
);

  logic [N-1:0] rot;
  logic [PW-1:0] off;
  logic [PW:0]   sum;

  // Doubled vector rotated so bit 0 corresponds to ptr.
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = PW'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PW + 1)'(N)) sum = sum - (PW + 1)'(N);
    found  = |req;
    winner = PW'(sum);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising whole transactions from NUM_REQ ports onto one memory port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned TIMEOUT = 1023,
  localparam int unsigned PTR_W   = ARB_PTR_W(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_ce_i,
  input  logic [NUM_REQ-1:0]                req_we_i,
  input  logic [NUM_REQ-1:0][ADDR_BUS-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0][WIDTH_W-1:0]   req_width_i,
  input  logic [NUM_REQ-1:0][DATA_BUS-1:0]  req_data_i,
  output logic [DATA_BUS-1:0]               req_data_o,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic                              mem_ce_o,
  output logic                              mem_we_o,
  output logic [ADDR_BUS-1:0]               mem_addr_o,
  output logic [WIDTH_W-1:0]                mem_width_o,
  output logic [DATA_BUS-1:0]               mem_data_o,
  input  logic [DATA_BUS-1:0]               mem_data_i,
  input  logic                              mem_ready_i,
  output logic [PTR_W-1:0]                  grant_o,
  output logic                              busy_o,
  output logic                              timeout_o
);

  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, grant_d, pick_idx;
  logic             pick_found, ce_d, timeout_d;
  mem_cmd_t         cmd_q, cmd_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req    (req_ce_i),
    .ptr    (ptr_q),
    .found  (pick_found),
    .winner (pick_idx)
  );

  // Next-state and next-register values.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_o;
    ce_d      = mem_ce_o;
    cmd_d     = cmd_q;
    wd_d      = wd_q;
    timeout_d = timeout_o;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          grant_d     = pick_idx;
          ce_d        = 1'b1;
          cmd_d.we    = req_we_i[pick_idx];
          cmd_d.addr  = req_addr_i[pick_idx];
          cmd_d.width = req_width_i[pick_idx];
          cmd_d.data  = req_data_i[pick_idx];
          wd_d        = '0;
        end
      end
      GRANT: begin
        // Watchdog only flags; an issued AXI transaction cannot be aborted.
        if (wd_q != WD_LIMIT) wd_d = wd_q + WD_W'(1);
        if (wd_d == WD_LIMIT) timeout_d = 1'b1;
        if (mem_ready_i) begin
          state_d = RELEASE;
          ce_d    = 1'b0;
          ptr_d   = (grant_o == LAST_IDX) ? '0 : grant_o + PTR_W'(1);
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_o   <= '0;
      mem_ce_o  <= 1'b0;
      cmd_q     <= '0;
      wd_q      <= '0;
      timeout_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_o   <= grant_d;
      mem_ce_o  <= ce_d;
      cmd_q     <= cmd_d;
      wd_q      <= wd_d;
      timeout_o <= timeout_d;
      busy_o    <= (state_d != IDLE);
    end
  end

  // Completion is routed back to the winner in the same cycle as mem_ready_i.
  always_comb begin
    req_ready_o = '0;
    if (state_q == GRANT && mem_ready_i) req_ready_o[grant_o] = 1'b1;
  end

  assign req_data_o  = mem_data_i;
  assign mem_we_o    = cmd_q.we;
  assign mem_addr_o  = cmd_q.addr;
  assign mem_width_o = cmd_q.width;
  assign mem_data_o  = cmd_q.data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model plus directed scenarios.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]       req_ce = '0, req_we = '0;
  logic [N-1:0][31:0] req_addr = '0, req_data = '0;
  logic [N-1:0][3:0]  req_width = '0;
  logic [31:0]        mem_data_i = '0;
  logic               mem_ready_i = 1'b0;

  logic [31:0] req_data_o, mem_addr_o, mem_data_o;
  logic [N-1:0] req_ready_o;
  logic        mem_ce_o, mem_we_o, busy_o, timeout_o;
  logic [3:0]  mem_width_o;
  logic [1:0]  grant_o;

  mem_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_ce_i(req_ce), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_width_i(req_width), .req_data_i(req_data),
    .req_data_o(req_data_o), .req_ready_o(req_ready_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ready_i(mem_ready_i),
    .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, then one dead cycle, then re-arbitrate.
  int          m_ptr = 0, m_owner = -1, m_grant = 0, m_wd = 0;
  bit          m_rel = 0, m_to = 0;
  logic        m_we = 0;
  logic [31:0] m_addr = '0, m_data = '0;
  logic [3:0]  m_width = '0;
  int          waits [N];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ptr = 0; m_owner = -1; m_grant = 0; m_wd = 0; m_rel = 0; m_to = 0;
      m_we = 0; m_addr = '0; m_data = '0; m_width = '0;
      for (int i = 0; i < N; i++) waits[i] = 0;
    end else if (m_owner >= 0) begin
      if (m_wd < TO) m_wd++;
      if (m_wd >= TO) m_to = 1;
      if (mem_ready_i) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_rel = 1;
      end
    end else if (m_rel) begin
      m_rel = 0;
    end else begin
      int w;
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req_ce[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        // A waiting requester must never see more than N-1 other grants.
        chk("fairness", 64'(waits[w] <= N - 1), 64'(1));
        for (int i = 0; i < N; i++) waits[i] = (i != w && req_ce[i]) ? waits[i] + 1 : 0;
        m_owner = w; m_grant = w; m_wd = 0;
        m_we = req_we[w]; m_addr = req_addr[w]; m_width = req_width[w]; m_data = req_data[w];
      end
    end
  end

  // Per-cycle comparison plus logs for the directed checks.
  int          cyc = 0, ce_cnt = 0;
  logic        ce_prev = 1'b0;
  logic [3:0]  rdy_log [$];
  logic [31:0] rdy_data [$];
  int          rdy_cyc [$], grant_log [$], rise_cyc [$];
  logic [31:0] rise_addr [$], rise_dat [$];

  always @(negedge clk) begin
    cyc++;
    chk("mem_ce", 64'(mem_ce_o), 64'(m_owner >= 0));
    chk("busy", 64'(busy_o), 64'(m_owner >= 0 || m_rel));
    chk("grant", 64'(grant_o), 64'(m_grant));
    chk("timeout", 64'(timeout_o), 64'(m_to));
    chk("req_ready", 64'(req_ready_o), 64'((m_owner >= 0 && mem_ready_i) ? (1 << m_owner) : 0));
    chk("req_data", 64'(req_data_o), 64'(mem_data_i));
    chk("mem_we", 64'(mem_we_o), 64'(m_we));
    chk("mem_addr", 64'(mem_addr_o), 64'(m_addr));
    chk("mem_width", 64'(mem_width_o), 64'(m_width));
    chk("mem_data", 64'(mem_data_o), 64'(m_data));
    if (mem_ce_o) ce_cnt++;
    if (mem_ce_o && !ce_prev) begin
      grant_log.push_back(int'(grant_o)); rise_cyc.push_back(cyc);
      rise_addr.push_back(mem_addr_o); rise_dat.push_back(mem_data_o);
    end
    if (req_ready_o != '0) begin
      rdy_log.push_back(req_ready_o); rdy_cyc.push_back(cyc); rdy_data.push_back(req_data_o);
    end
    ce_prev = mem_ce_o;
  end

  // Stimulus state
  bit          auto_resp = 1, rand_mode = 0, use_fixed = 0;
  int          lat = 2, resp_cnt = 0;
  logic [31:0] fixed_data = '0;
  logic [N-1:0] keep = '0;

  task automatic clear_logs();
    rdy_log.delete(); rdy_data.delete(); rdy_cyc.delete(); grant_log.delete();
    rise_cyc.delete(); rise_addr.delete(); rise_dat.delete(); ce_cnt = 0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] a,
                         input logic [3:0] w, input logic [31:0] d);
    req_we[i] = we; req_addr[i] = a; req_width[i] = w; req_data[i] = d; req_ce[i] = 1'b1;
  endtask

  // One clock: sample completions mid-cycle, then drive responder and requesters after the edge.
  task automatic step();
    logic [N-1:0] seen;
    @(negedge clk);
    seen = req_ready_o;
    @(posedge clk);
    #1;
    mem_ready_i = 1'b0;
    if (auto_resp && mem_ce_o) begin
      resp_cnt++;
      if (resp_cnt == lat) begin
        mem_ready_i = 1'b1;
        mem_data_i  = use_fixed ? fixed_data : $urandom;
      end
    end else begin
      resp_cnt = 0;
      if (rand_mode) lat = $urandom_range(1, 4);
    end
    if (rand_mode && !mem_ce_o && $urandom_range(0, 7) == 0) begin
      mem_ready_i = 1'b1; mem_data_i = $urandom;
    end
    for (int i = 0; i < N; i++) begin
      if (rand_mode) begin
        req_we[i] = 1'($urandom); req_addr[i] = $urandom;
        req_width[i] = 4'($urandom); req_data[i] = $urandom;
      end
      if (seen[i]) req_ce[i] = 1'b0;
      else if (!req_ce[i] && (keep[i] || (rand_mode && $urandom_range(0, 3) == 0))) req_ce[i] = 1'b1;
    end
  endtask

  task automatic drain();
    keep = '0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (!busy_o && req_ce == '0) break;
    end
    chk("drain_idle", 64'({busy_o, req_ce}), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b0; step(); step(); rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ce", 64'(mem_ce_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_grant", 64'(grant_o), 64'(0));
    chk("rst_timeout", 64'(timeout_o), 64'(0));
    chk("rst_addr", 64'(mem_addr_o), 64'(0));
    rst = 1'b1;
    step();

    // Single write from requester 2, ready in the 3rd GRANT cycle.
    clear_logs(); lat = 3;
    set_req(2, 1'b1, 32'h100, 4'h4, 32'hDEADBEEF);
    repeat (10) step();
    chk("t1_ce_cycles", 64'(ce_cnt), 64'(3));
    chk("t1_ready_count", 64'(rdy_log.size()), 64'(1));
    chk("t1_ready_val", 64'(rdy_log.size() > 0 ? rdy_log[0] : 4'hF), 64'(4'b0100));
    chk("t1_addr", 64'(rise_addr.size() > 0 ? rise_addr[0] : 32'hFFFF_FFFF), 64'(32'h100));
    chk("t1_data", 64'(rise_dat.size() > 0 ? rise_dat[0] : 32'h0), 64'(32'hDEADBEEF));

    // Pointer moved past 2: with everyone requesting, 3 wins, then 0.
    clear_logs(); lat = 2; keep = '1; req_ce = '1;
    repeat (12) step();
    chk("ptr_first", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(3));
    chk("ptr_second", 64'(grant_log.size() > 1 ? grant_log[1] : -1), 64'(0));
    drain();

    // All four continuously from reset.
    do_reset(); clear_logs(); keep = '1; req_ce = '1; lat = 2;
    repeat (24) step();
    for (int i = 0; i < 5; i++)
      chk("rr_order", 64'(grant_log.size() > i ? grant_log[i] : -1), 64'(i % N));
    for (int i = 1; i < 4; i++)
      chk("issue_gap", 64'(rdy_cyc.size() > i ? rdy_cyc[i] - rdy_cyc[i-1] : -1), 64'(4));
    drain();

    // Read data routing to requester 1.
    clear_logs(); use_fixed = 1; fixed_data = 32'h12345678; lat = 2;
    set_req(1, 1'b0, 32'h200, 4'h4, 32'h0);
    repeat (8) step();
    use_fixed = 0;
    chk("rd_ready_count", 64'(rdy_log.size()), 64'(1));
    chk("rd_ready_val", 64'(rdy_log.size() > 0 ? rdy_log[0] : 4'hF), 64'(4'b0010));
    chk("rd_data", 64'(rdy_data.size() > 0 ? rdy_data[0] : 32'h0), 64'(32'h12345678));
    drain();

    // Requester 3 arrives in the completion cycle of requester 0.
    clear_logs(); lat = 2;
    set_req(0, 1'b1, 32'h300, 4'h2, 32'hA5A5A5A5);
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_ready_i) begin
        set_req(3, 1'b0, 32'h340, 4'h1, 32'h0);
        break;
      end
    end
    repeat (8) step();
    chk("simul_grant3", 64'(grant_log.size() > 1 ? grant_log[1] : -1), 64'(3));
    chk("simul_delay", 64'((rise_cyc.size() > 1 && rdy_cyc.size() > 0) ? rise_cyc[1] - rdy_cyc[0] : -1), 64'(3));
    drain();

    // Stray downstream ready while idle.
    clear_logs(); auto_resp = 0;
    mem_ready_i = 1'b1; mem_data_i = 32'h5555AAAA;
    step(); step();
    chk("stray_ready", 64'(rdy_log.size()), 64'(0));
    chk("stray_busy", 64'(busy_o), 64'(0));
    auto_resp = 1;

    // Winner drops its request mid-GRANT; completion still returns to it.
    clear_logs(); lat = 3;
    set_req(1, 1'b1, 32'h400, 4'h4, 32'h11112222);
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_ce_o) break;
    end
    req_ce[1] = 1'b0;
    repeat (6) step();
    chk("drop_ready_val", 64'(rdy_log.size() > 0 ? rdy_log[0] : 4'hF), 64'(4'b0010));
    chk("drop_ready_count", 64'(rdy_log.size()), 64'(1));
    drain();

    // Randomized traffic against the model.
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    drain();

    // Watchdog: downstream stalls.
    auto_resp = 0; clear_logs();
    set_req(0, 1'b0, 32'h500, 4'h4, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_ce_o) break;
    end
    for (int g = 1; g <= TO; g++) begin
      chk("to_low", 64'(timeout_o), 64'(0));
      step();
    end
    chk("to_high", 64'(timeout_o), 64'(1));
    repeat (4) step();
    chk("to_sticky", 64'(timeout_o), 64'(1));
    mem_ready_i = 1'b1; mem_data_i = 32'hCAFE0001;
    step(); step();
    chk("to_late_ready", 64'(rdy_log.size() > 0 ? rdy_log[0] : 4'hF), 64'(4'b0001));
    chk("to_after_done", 64'(timeout_o), 64'(1));
    drain();

    // Asynchronous reset in the middle of GRANT.
    set_req(2, 1'b1, 32'h600, 4'h4, 32'h77);
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_ce_o) break;
    end
    #2 rst = 1'b0;
    #1;
    chk("arst_ce", 64'(mem_ce_o), 64'(0));
    chk("arst_busy", 64'(busy_o), 64'(0));
    chk("arst_timeout", 64'(timeout_o), 64'(0));
    req_ce[2] = 1'b0;
    set_req(1, 1'b0, 32'h700, 4'h4, 32'h0);
    set_req(3, 1'b0, 32'h740, 4'h4, 32'h0);
    step(); step();
    rst = 1'b1; auto_resp = 1; lat = 2; clear_logs();
    repeat (6) step();
    chk("arst_first_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(1));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
